// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus WIDTH-cycle shift-add multiply and
// restoring divide/remainder, behind a ready/start handshake with a one-cycle done pulse.
module multicycle_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpAnd = 4'b0011;
    localparam logic [3:0] OpOr  = 4'b0100;
    localparam logic [3:0] OpXor = 4'b0101;
    localparam logic [3:0] OpNot = 4'b0110;
    localparam logic [3:0] OpShl = 4'b0111;
    localparam logic [3:0] OpShr = 4'b1000;
    localparam logic [3:0] OpSlt = 4'b1001;
    localparam logic [3:0] OpEq  = 4'b1010;
    localparam logic [3:0] OpMul = 4'b1011;
    localparam logic [3:0] OpDiv = 4'b1100;
    localparam logic [3:0] OpRem = 4'b1101;

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  acc_q, mcand_q, mplier_q;
    logic [WIDTH-1:0]  rem_q, quo_q;
    logic [WIDTH-1:0]  result_q;
    logic              done_q, zero_q, carry_q, div_zero_q;

    logic              is_multi, finish;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  mul_next, rem_next, quo_next;
    logic [WIDTH:0]    div_shift, div_diff;
    logic [WIDTH-1:0]  res_d;
    logic              carry_d;

    assign is_multi = (op_q == OpMul) || (op_q == OpDiv) || (op_q == OpRem);
    assign finish   = (state_q == StCalc) && (!is_multi || (cnt_q == CntW'(WIDTH - 1)));

    // One multiply/divide step; the final step's values feed the result directly.
    assign mul_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign rem_next  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign quo_next  = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    assign sum       = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        case (op_q)
            OpAdd: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            OpSub: begin
                res_d   = a_q - b_q;
                carry_d = (a_q < b_q);
            end
            OpAnd:   res_d = a_q & b_q;
            OpOr:    res_d = a_q | b_q;
            OpXor:   res_d = a_q ^ b_q;
            OpNot:   res_d = ~a_q;
            OpShl:   res_d = a_q << 1;
            OpShr:   res_d = a_q >> 1;
            OpSlt:   res_d = WIDTH'(a_q < b_q);
            OpEq:    res_d = WIDTH'(a_q == b_q);
            OpMul:   res_d = mul_next;
            OpDiv:   res_d = quo_next;
            OpRem:   res_d = rem_next;
            default: res_d = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StCalc;
            StCalc:  if (finish) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (state_q == StIdle && start) begin
                op_q     <= alu_op;
                a_q      <= a;
                b_q      <= b;
                cnt_q    <= '0;
                acc_q    <= '0;
                mcand_q  <= a;
                mplier_q <= b;
                rem_q    <= '0;
                quo_q    <= a;
            end else if (state_q == StCalc) begin
                cnt_q    <= cnt_q + 1'b1;
                acc_q    <= mul_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                rem_q    <= rem_next;
                quo_q    <= quo_next;
            end
            if (finish) begin
                result_q   <= res_d;
                zero_q     <= (res_d == '0);
                carry_q    <= carry_d;
                div_zero_q <= ((op_q == OpDiv) || (op_q == OpRem)) && (b_q == '0);
            end
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = done_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu (WIDTH=16): vector table plus reset/back-to-back sequences.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [3:0]  alu_op;
    logic [15:0] a, b;
    logic        ready, done, zero, carry, div_zero;
    logic [15:0] result;

    int total = 0;
    int bad   = 0;

    multicycle_alu #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .alu_op   (alu_op),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle; returns just after the cycle following done.
    task automatic run_op(input vec_t v);
        int cycles;
        bit busy_ok;
        check({v.name, " ready_before"}, ready, 1);
        start  = 1'b1;
        alu_op = v.op;
        a      = v.va;
        b      = v.vb;
        @(posedge clk); #1;
        start   = 1'b0;
        alu_op  = 4'b1011;
        a       = 16'($urandom);
        b       = 16'($urandom);
        cycles  = 0;
        busy_ok = 1'b1;
        while (!done && cycles < 40) begin
            if (ready !== 1'b0) busy_ok = 1'b0;
            start = 1'b1;
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        check({v.name, " latency"}, cycles, v.lat);
        check({v.name, " ready_low_in_calc"}, busy_ok, 1);
        check({v.name, " result"}, result, v.res);
        check({v.name, " zero"}, zero, v.z);
        check({v.name, " carry"}, carry, v.c);
        check({v.name, " div_zero"}, div_zero, v.dz);
        check({v.name, " ready_at_done"}, ready, 1);
        @(posedge clk); #1;
        check({v.name, " done_one_cycle"}, done, 0);
        check({v.name, " result_held"}, result, v.res);
    endtask

    initial begin
        vec_t v;
        int   saw_done;

        vecs.push_back('{"add_wrap",  4'b0001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{"add",       4'b0001, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"sub_borrow",4'b0010, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{"sub",       4'b0010, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"and",       4'b0011, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"or",        4'b0100, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"xor",       4'b0101, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{"not",       4'b0110, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"shl",       4'b0111, 16'h8001, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"shr",       4'b1000, 16'h8001, 16'h0000, 16'h4000, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"slt_t",     4'b1001, 16'h0002, 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{"slt_f",     4'b1001, 16'h0003, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{"slt_uns",   4'b1001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{"eq_f",      4'b1010, 16'h0007, 16'h0008, 16'h0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{"mul",       4'b1011, 16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b0, 1'b0, 16});
        vecs.push_back('{"mul_max",   4'b1011, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16});
        vecs.push_back('{"div",       4'b1100, 16'd1000, 16'd7,    16'd142,  1'b0, 1'b0, 1'b0, 16});
        vecs.push_back('{"rem",       4'b1101, 16'd1000, 16'd7,    16'd6,    1'b0, 1'b0, 1'b0, 16});
        vecs.push_back('{"div_small", 4'b1100, 16'd5,    16'd10,   16'd0,    1'b1, 1'b0, 1'b0, 16});
        vecs.push_back('{"div_zero",  4'b1100, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16});
        vecs.push_back('{"rem_zero",  4'b1101, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b1, 16});
        vecs.push_back('{"op0",       4'b0000, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{"op14",      4'b1110, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{"op15",      4'b1111, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{"add_carry", 4'b0001, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b1, 1'b0, 1});

        rst    = 1'b1;
        start  = 1'b0;
        alu_op = '0;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ready", ready, 1);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst zero", zero, 0);
        check("rst carry", carry, 0);
        check("rst div_zero", div_zero, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Abort a divide in its 5th CALC cycle; reset also wins over a simultaneous start.
        start  = 1'b1;
        alu_op = 4'b1100;
        a      = 16'd1000;
        b      = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort ready_mid", ready, 0);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check("abort ready", ready, 1);
        check("abort done", done, 0);
        check("abort result", result, 0);
        check("abort zero", zero, 0);
        check("abort carry", carry, 0);
        check("abort div_zero", div_zero, 0);
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) saw_done++;
        end
        check("abort no_done", saw_done, 0);
        check("abort still_idle", ready, 1);
        v = '{"sub_after_abort", 4'b0010, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1};
        run_op(v);

        // EQ then SLT issued in the EQ done cycle.
        start  = 1'b1;
        alu_op = 4'b1010;
        a      = 16'd7;
        b      = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b eq done", done, 1);
        check("b2b eq result", result, 1);
        check("b2b eq ready", ready, 1);
        start  = 1'b1;
        alu_op = 4'b1001;
        a      = 16'd2;
        b      = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b gap done", done, 0);
        check("b2b gap busy", ready, 0);
        check("b2b gap result", result, 1);
        @(posedge clk); #1;
        check("b2b slt done", done, 1);
        check("b2b slt result", result, 1);
        check("b2b slt zero", zero, 0);
        @(posedge clk); #1;
        check("b2b slt done_one_cycle", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits (>=4).
REQ-002 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 Port: start  in  1  request; accepted only when ready=1.
REQ-005 Port: alu_op  in  4  operation code, sampled at accept.
REQ-006 Port: a, b  in  WIDTH  operands, sampled at accept.
REQ-007 Port: ready  out  1  high when idle and able to accept.
REQ-008 Port: done  out  1  one-cycle pulse: result and flags valid.
REQ-009 Port: result  out  WIDTH  registered result, held until next completion.
REQ-010 Port: zero, carry, div_zero  out  1 each  registered flags, updated with result.

Function
REQ-011 States SHALL be IDLE and CALC; ready SHALL equal (state==IDLE).
REQ-012 Accept: start=1 and ready=1 at edge N; a, b, alu_op latched internally; state -> CALC; later changes to inputs SHALL have no effect.
REQ-013 start while in CALC SHALL be ignored (not queued).
REQ-014 Single-cycle ops SHALL complete at edge N+1: result/flags written, done=1 for the cycle after edge N+1, state -> IDLE.
REQ-015 Single-cycle ops: 0001 ADD a+b; 0010 SUB a-b; 0011 AND; 0100 OR; 0101 XOR; 0110 NOT a; 0111 a<<1; 1000 a>>1 (logical); 1001 unsigned a<b -> 1 else 0; 1010 a==b -> 1 else 0.
REQ-016 Multi-cycle ops: 1011 MUL (low WIDTH bits of unsigned a*b, shift-add, one bit/cycle); 1100 DIV unsigned quotient; 1101 REM unsigned remainder (restoring division, one bit/cycle).
REQ-017 Multi-cycle ops SHALL complete at edge N+WIDTH exactly; done high the cycle after.
REQ-018 Codes 0000, 1110, 1111 SHALL complete as single-cycle with result=0.
REQ-019 zero SHALL equal (result==0) for every completed op.
REQ-020 carry SHALL be carry-out of ADD, borrow (a<b unsigned) of SUB, else 0.
REQ-021 Divide by zero (b=0, DIV/REM): SHALL still take WIDTH cycles; DIV result all ones, REM result=a, div_zero=1; div_zero=0 for all other completions.
REQ-022 Back-to-back: start asserted in the done cycle SHALL be accepted (ready=1 then); done of previous op unaffected.
REQ-023 done SHALL be high for exactly one cycle per accepted op; never high without a prior accept.
REQ-024 result/flags SHALL hold their value between completions; no intermediate values visible.
REQ-025 All arithmetic modulo 2^WIDTH; shifts fill with 0; shifted-out bit discarded.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, ready=1, done=0, result=0, zero=0, carry=0, div_zero=0, iteration counter 0.
REQ-027 rst during CALC SHALL abort the op; no done pulse for it; rst overrides simultaneous start.
REQ-028 First accept possible at first edge with rst=0.

Verification (WIDTH=16)
REQ-029 ADD a=0xFFFF b=0x0001 -> done 1 cycle after accept edge +1; result=0x0000, zero=1, carry=1.
REQ-030 MUL a=0x0123 b=0x0010 -> done after 16 cycles in CALC; result=0x1230, zero=0; ready=0 throughout CALC; start pulses mid-op ignored.
REQ-031 DIV a=1000 b=7 -> result=142; REM same operands -> result=6; div_zero=0.
REQ-032 DIV a=0x1234 b=0 -> result=0xFFFF, div_zero=1; REM -> result=0x1234, div_zero=1.
REQ-033 Start DIV, assert rst at 5th CALC cycle -> no done; all outputs at reset values; next SUB a=3 b=5 -> result=0xFFFE, carry=1.
REQ-034 SLT a=2 b=3 accepted in done cycle of prior EQ a=b=7 -> EQ result=1, then SLT result=1, two done pulses.
